// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state type.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int ST_FULL     = 0;
    localparam int ST_EMPTY    = 1;
    localparam int ST_BUSY     = 2;
    localparam int ST_OVF      = 3;
    localparam int ST_COUNT    = 8;
    localparam int CTRL_IRQ_EN = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus slice seen by the UART: strobes, address, write data
// and the combinational read data returned by the responder.
interface mmio_uart_tx_if;

    logic        sel;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, we, re, addr, wdata, input rdata);
    modport slave  (input sel, we, re, addr, wdata, output rdata);

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter
// and the IDLE/START/DATA/STOP serializer driving a registered tx line.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [15:0] BAUD_DIV_RESET = 16'd867
) (
    input  logic             clk,
    input  logic             reset,
    mmio_uart_tx_if.slave    bus,
    output logic             tx,
    output logic             irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]     reg_idx;
    logic           wr_en;
    logic           rd_en;
    logic           push_req;
    logic           w1c_ovf;
    logic [15:0]    bauddiv;
    logic           irq_en;
    logic           overflow;
    logic [31:0]    status;

    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;

    uart_tx_state_t state, state_n;
    logic [7:0]     shift, shift_n;
    logic [2:0]     bit_idx, bit_idx_n;
    logic [15:0]    baud_cnt, baud_cnt_n;
    logic           tx_n;
    logic           bit_done;

    // The SoC decodes the window, so only the register-select bits matter here.
    logic unused_bits;
    assign unused_bits = ^{BASE_ADDR, bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16]};

    assign reg_idx  = bus.addr[3:2];
    assign wr_en    = bus.sel && bus.we;
    assign rd_en    = bus.sel && bus.re;
    assign push_req = wr_en && (reg_idx == REG_TXDATA);
    assign w1c_ovf  = wr_en && (reg_idx == REG_STATUS) && bus.wdata[ST_OVF];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (bus.wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bauddiv  <= BAUD_DIV_RESET;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && (reg_idx == REG_BAUDDIV)) begin
                bauddiv <= bus.wdata[15:0];
            end
            if (wr_en && (reg_idx == REG_CTRL)) begin
                irq_en <= bus.wdata[CTRL_IRQ_EN];
            end
            // A same-cycle pop makes room, so only a truly dropped push is sticky.
            if (push_req && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end else if (w1c_ovf) begin
                overflow <= 1'b0;
            end
            irq <= fifo_empty && (state == IDLE) && irq_en;
        end
    end

    always_comb begin
        status                 = '0;
        status[ST_FULL]        = fifo_full;
        status[ST_EMPTY]       = fifo_empty;
        status[ST_BUSY]        = (state != IDLE);
        status[ST_OVF]         = overflow;
        status[ST_COUNT +: CW] = fifo_count;
    end

    always_comb begin
        bus.rdata = '0;
        if (rd_en) begin
            case (reg_idx)
                REG_STATUS:  bus.rdata = status;
                REG_BAUDDIV: bus.rdata = {16'd0, bauddiv};
                REG_CTRL:    bus.rdata = {31'd0, irq_en};
                default:     bus.rdata = '0;
            endcase
        end
    end

    assign bit_done = (baud_cnt == '0);

    // tx_n is the line level for the coming bit, so tx changes on the same
    // edge as the state it belongs to.
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        baud_cnt_n = baud_cnt;
        tx_n       = tx;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_n    = fifo_dout;
                    baud_cnt_n = bauddiv;
                    tx_n       = 1'b0;
                    state_n    = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n    = DATA;
                    bit_idx_n  = '0;
                    baud_cnt_n = bauddiv;
                    tx_n       = shift[0];
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_cnt_n = bauddiv;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shift_n   = shift >> 1;
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shift[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_n    = fifo_dout;
                        baud_cnt_n = bauddiv;
                        tx_n       = 1'b0;
                        state_n    = START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_idx  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            bit_idx  <= bit_idx_n;
            baud_cnt <= baud_cnt_n;
            tx       <= tx_n;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_n;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register vector table plus hand-written
// frame, back-to-back, overflow, interrupt and mid-frame reset sequences.
module tb_mmio_uart_tx;

    localparam logic [31:0] A_TXDATA = 32'h1000_0000;
    localparam logic [31:0] A_STATUS = 32'h1000_0004;
    localparam logic [31:0] A_BAUD   = 32'h1000_0008;
    localparam logic [31:0] A_CTRL   = 32'h1000_000C;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic irq;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR      (32'h1000_0000),
        .FIFO_DEPTH     (8),
        .BAUD_DIV_RESET (16'd867)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        sel;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.sel   = 1'b0;
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.sel   = 1'b1;
        bus.we    = 1'b1;
        bus.re    = 1'b0;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.sel  = 1'b1;
        bus.re   = 1'b1;
        bus.we   = 1'b0;
        bus.addr = a;
        #1;
        d = bus.rdata;
        bus_idle();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [9:0]  lvl;
        logic [39:0] got40, exp40;
        logic [89:0] got90;
        logic [9:0]  frame;
        logic [7:0]  b;
        int          lows;

        bus_idle();
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("tx_in_reset", {63'd0, tx}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("reset_tx", {63'd0, tx}, 64'd1);
        check("reset_irq", {63'd0, irq}, 64'd0);
        rd(A_STATUS, r);
        check("reset_status", {32'd0, r}, 64'h2);

        // Register access table.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, A_BAUD,         32'h0,         32'h363};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, A_CTRL,         32'h0,         32'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, A_TXDATA,       32'h0,         32'h0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, A_BAUD,         32'hABCD_1234, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, A_BAUD,         32'h0,         32'h1234};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, A_BAUD,         32'h0,         32'h0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, A_BAUD,         32'h0,         32'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h1000_0018,  32'h0,         32'h1234};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, A_CTRL,         32'hFFFF_FFFE, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, A_CTRL,         32'h0,         32'h0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, A_CTRL,         32'h1,         32'h0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, A_CTRL,         32'h0,         32'h1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, A_CTRL,         32'h0,         32'h0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, A_STATUS,       32'hFFFF_FFFF, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, A_STATUS,       32'h0,         32'h2};
        vecs[15] = '{1'b0, 1'b1, 1'b0, A_BAUD,         32'h5,         32'h0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, A_BAUD,         32'h0,         32'h1234};

        for (int i = 0; i < 17; i++) begin
            bus.sel   = vecs[i].sel;
            bus.we    = vecs[i].we;
            bus.re    = vecs[i].re;
            bus.addr  = vecs[i].addr;
            bus.wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec[%0d]", i), {32'd0, bus.rdata}, {32'd0, vecs[i].exp});
            @(posedge clk);
            @(negedge clk);
            bus_idle();
        end

        // Single 0x55 frame, 4 clocks per bit.
        wr(A_BAUD, 32'd3);
        wr(A_TXDATA, 32'h55);
        check("tx_before_E1", {63'd0, tx}, 64'd1);
        lvl = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 40; k++) begin
            exp40[k] = lvl[k / 4];
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            got40[k] = tx;
            if (k == 0) check("tx_at_E1", {63'd0, tx}, 64'd0);
            if (k == 20) begin
                rd(A_STATUS, r);
                check("busy_mid_frame", {63'd0, r[2]}, 64'd1);
            end
        end
        check("frame_0x55", {24'd0, got40}, {24'd0, exp40});
        cycles(1);
        rd(A_STATUS, r);
        check("status_after_frame", {32'd0, r}, 64'h2);
        check("tx_idle_after_frame", {63'd0, tx}, 64'd1);

        // Nine bytes in consecutive cycles at one clock per bit.
        wr(A_BAUD, 32'd0);
        bus.sel   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = A_TXDATA;
        bus.wdata = 32'h0;
        for (int i = 0; i <= 90; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i >= 1) got90[i-1] = tx;
            if (i < 8) bus.wdata = 32'(i + 1);
            else if (i == 8) bus_idle();
        end
        for (int f = 0; f < 9; f++) begin
            b     = 8'(f);
            frame = {1'b1, b, 1'b0};
            check($sformatf("b2b_frame%0d", f), {54'd0, got90[f*10 +: 10]}, {54'd0, frame});
        end
        cycles(1);
        rd(A_STATUS, r);
        check("b2b_status_end", {32'd0, r}, 64'h2);

        // Overflow: ten bytes against slow frames.
        wr(A_BAUD, 32'd15);
        bus.sel  = 1'b1;
        bus.we   = 1'b1;
        bus.addr = A_TXDATA;
        for (int i = 0; i < 10; i++) begin
            bus.wdata = 32'(i);
            @(posedge clk);
            @(negedge clk);
        end
        bus_idle();
        rd(A_STATUS, r);
        check("ovf_status", {32'd0, r}, 64'h80D);
        wr(A_STATUS, 32'h0);
        rd(A_STATUS, r);
        check("ovf_write0_keeps", {32'd0, r}, 64'h80D);
        wr(A_STATUS, 32'h8);
        rd(A_STATUS, r);
        check("ovf_w1c", {32'd0, r}, 64'h805);
        apply_reset();

        // Interrupt timing with two clocks per bit.
        wr(A_BAUD, 32'd1);
        wr(A_CTRL, 32'd1);
        check("irq_en_edge", {63'd0, irq}, 64'd0);
        cycles(1);
        check("irq_idle_high", {63'd0, irq}, 64'd1);
        wr(A_TXDATA, 32'hA5);
        check("irq_at_write_edge", {63'd0, irq}, 64'd1);
        cycles(1);
        check("irq_fall", {63'd0, irq}, 64'd0);
        cycles(20);
        check("irq_at_stop_end", {63'd0, irq}, 64'd0);
        rd(A_STATUS, r);
        check("irq_status_idle", {32'd0, r}, 64'h2);
        cycles(1);
        check("irq_rise", {63'd0, irq}, 64'd1);

        // Reset in the middle of a data bit with bytes still queued.
        wr(A_CTRL, 32'd0);
        wr(A_BAUD, 32'd3);
        bus.sel  = 1'b1;
        bus.we   = 1'b1;
        bus.addr = A_TXDATA;
        bus.wdata = 32'h00;
        @(posedge clk);
        @(negedge clk);
        bus.wdata = 32'h0F;
        @(posedge clk);
        @(negedge clk);
        bus.wdata = 32'hF0;
        @(posedge clk);
        @(negedge clk);
        bus_idle();
        cycles(6);
        check("mid_data_tx_low", {63'd0, tx}, 64'd0);
        rd(A_STATUS, r);
        check("mid_data_status", {32'd0, r}, 64'h204);
        #1 reset = 1'b1;
        #1;
        check("async_reset_tx", {63'd0, tx}, 64'd1);
        @(negedge clk);
        reset = 1'b0;
        rd(A_STATUS, r);
        check("post_reset_status", {32'd0, r}, 64'h2);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("no_frames_after_reset", 64'(lows), 64'd0);
        rd(A_BAUD, r);
        check("post_reset_baud", {32'd0, r}, 64'h363);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a responder on the CPU data-memory bus, alongside data memory in the SoC.
- The CPU stores bytes to a data register. The block queues them in a FIFO and serializes each one as an 8N1 frame on `tx`.
- The CPU polls a status register for flow control.
- The SoC top address-decodes and forwards bus strobes only for this block's window.

Parameters:
- `BASE_ADDR`, `32'h1000_0000`: base of the 16-byte register window; bits [3:2] of `addr` select the register.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of two, ≥2.
- `BAUD_DIV_RESET`, `16'd867`: reset value of BAUDDIV; bit period is BAUDDIV+1 clocks.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `sel`  in  1  access targets this block's window (decoded by the SoC top)
- `addr`  in  32  byte address; only [3:2] used
- `we`  in  1  write strobe; valid with `sel`
- `re`  in  1  read strobe; valid with `sel`
- `wdata`  in  32  write data
- `rdata`  out  32  read data, combinational from `addr`/state
- `tx`  out  1  serial line, idle high
- `irq`  out  1  level interrupt: FIFO empty AND FSM idle AND IRQ_EN

Behaviour:
- Register map, offset from BASE_ADDR:
  - 0x0 TXDATA: write pushes `wdata[7:0]`; reads return 0.
  - 0x4 STATUS: read-only except W1C of bit 3.
    - bit0 `full`
    - bit1 `empty`
    - bit2 `busy` (FSM not IDLE)
    - bit3 `overflow` (sticky)
    - bits[11:8] `count`; upper bits 0.
  - 0x8 BAUDDIV: R/W [15:0].
  - 0xC CTRL: R/W; bit0 IRQ_EN.
- Bus timing:
  - Writes take effect at the rising edge where `sel`&&`we`.
  - Reads are combinational, same cycle. `rdata`=0 when !`sel` or !`re`.
  - Reads have no side effects.
- Reset values: `tx`=1, `rdata`=0, `irq`=0, FIFO empty, count=0, overflow=0, BAUDDIV=`BAUD_DIV_RESET`, CTRL=0, FSM=IDLE.
- Reset mid-frame: `tx` returns to 1 asynchronously and queued data is discarded.
- FIFO:
  - A push when full is dropped and sets `overflow`; FIFO contents are unchanged.
  - A simultaneous push and pop in the same cycle both occur; count is unchanged.
  - If a push while full coincides with a pop, the push succeeds and `overflow` is not set.
  - Pointers wrap modulo `FIFO_DEPTH`. Count width is clog2(`FIFO_DEPTH`)+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If FIFO non-empty, pop the head into the shift register, load the bit counter from BAUDDIV, go to START.
  - Latency: data written at edge E0 → `tx` falls at edge E1.
  - START: `tx`=0 for BAUDDIV+1 clocks → DATA, bit index 0.
  - DATA: `tx`=shift[0], LSB first; shift right each bit period; after bit 7 → STOP.
  - STOP: `tx`=1 for BAUDDIV+1 clocks. Then pop the next byte if the FIFO is non-empty (back-to-back frames, no idle gap); otherwise go to IDLE.
- Baud counter reload:
  - The counter reloads from BAUDDIV at every bit boundary.
  - A BAUDDIV write mid-frame therefore applies from the next bit.
  - BAUDDIV=0 gives a 1-clock bit period.
- `tx` is driven from a register: glitch-free, no combinational path from the bus.
- `irq` is registered and updates one cycle after its condition changes.
- A W1C write of STATUS bit3 in the same cycle as an overflowing push leaves `overflow`=1 (set wins).

Decomposition:
- Package `uart_pkg`:
  - register offset localparams
  - STATUS bit positions
  - `uart_tx_state_t` enum (IDLE, START, DATA, STOP)
- Sub-module `sync_fifo`:
  - parameterised WIDTH/DEPTH
  - ports: push, pop, din, dout, full, empty, count
  - same `clk` and asynchronous active-high `reset`
- `mmio_uart_tx` holds the register decode, baud counter and FSM.

Test Plan:
- Reset, then read STATUS → `rdata`=0x00000002, `tx`=1, `irq`=0.
- BAUDDIV=3, write TXDATA 0x55 → `tx`=0 one cycle after the write edge.
  - Then `tx` sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 clocks; frame is 40 clocks.
  - STATUS bit2=1 during the frame, 0 afterwards.
- BAUDDIV=0, write 9 bytes (0x00..0x08) in 9 consecutive cycles.
  - First byte pops on the edge after its write, so all 9 bytes are accepted.
  - Overflow=0, and 9 frames are sent back-to-back with no idle gap.
- BAUDDIV=15 (frames slow), write 10 bytes in 10 consecutive cycles.
  - Bytes 0x00..0x08 are accepted; byte 10 is dropped.
  - STATUS reads `full`=1, `overflow`=1; W1C of bit3 → `overflow`=0.
- CTRL=1, send one byte with BAUDDIV=1.
  - `irq` rises one cycle after STOP completes.
  - `irq` falls one cycle after the next TXDATA write.
- Assert `reset` mid-DATA with 3 bytes queued → `tx`=1 immediately, STATUS=0x00000002 after release, no further frames.
